// File: rtl/shift_add_mult_unit.sv
// Pipelined shift-add leak multiplier: mult_ans = floor(potential * beta / 2^BETA_W).
// One beta bit per stage, one operand pair accepted per clock.
module shift_add_mult_unit #(
  parameter int POT_W  = 8,
  parameter int BETA_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [POT_W-1:0] potential,
  input  logic [BETA_W-1:0]       beta,
  output logic                    out_valid,
  output logic signed [POT_W-1:0] mult_ans
);

  localparam int ACC_W = POT_W + BETA_W;

  genvar k;
  for (k = 0; k < BETA_W; k++) begin : g_stage
    logic                    v_in;
    logic signed [POT_W-1:0] p_in;
    logic [BETA_W-k-1:0]     b_in;
    logic signed [ACC_W-1:0] a_in;
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W-1:0] part;
    logic                    vld_q;
    logic signed [ACC_W-1:0] acc_q;

    if (k == 0) begin : g_head
      assign v_in = in_valid;
      assign p_in = potential;
      assign b_in = beta;
      assign a_in = '0;
    end else begin : g_link
      assign v_in = g_stage[k-1].vld_q;
      assign p_in = g_stage[k-1].g_fwd.pot_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign a_in = g_stage[k-1].acc_q;
    end

    assign ext  = {{BETA_W{p_in[POT_W-1]}}, p_in};
    assign part = b_in[0] ? (ext << k) : '0;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        acc_q <= '0;
      end else begin
        vld_q <= v_in;
        acc_q <= a_in + part;
      end
    end

    // Only the beta bits still to be consumed travel down the pipe.
    if (k < BETA_W - 1) begin : g_fwd
      logic signed [POT_W-1:0] pot_q;
      logic [BETA_W-k-2:0]     b_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pot_q <= '0;
          b_q   <= '0;
        end else begin
          pot_q <= p_in;
          b_q   <= b_in[BETA_W-k-1:1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      mult_ans  <= '0;
    end else begin
      out_valid <= g_stage[BETA_W-1].vld_q;
      if (g_stage[BETA_W-1].vld_q)
        mult_ans <= g_stage[BETA_W-1].acc_q[ACC_W-1:BETA_W];
    end
  end

endmodule

// File: tb/tb_shift_add_mult_unit.sv
// Directed and streaming checks for shift_add_mult_unit.
// Expected results come from hand values or a floor(p*b/16) reference.
module tb_shift_add_mult_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic signed [7:0] potential;
  logic [3:0]        beta;
  logic              out_valid;
  logic signed [7:0] mult_ans;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         due;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  shift_add_mult_unit #(.POT_W(8), .BETA_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .potential (potential),
    .beta      (beta),
    .out_valid (out_valid),
    .mult_ans  (mult_ans)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mult(input logic signed [7:0] p,
                                          input logic [3:0] b);
    int pi;
    int bi;
    int r;
    pi = p;
    bi = b;
    r  = (pi * bi) >>> 4;
    return r[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then check the output against the scoreboard.
  task automatic step(input logic v, input logic [7:0] p,
                      input logic [3:0] b, input logic [7:0] exp,
                      input string tag);
    exp_t e;
    logic due;
    in_valid  = v;
    potential = p;
    beta      = b;
    @(posedge clk);
    #1;
    cyc++;
    if (v) begin
      e.due = cyc + 4;
      e.val = exp;
      exp_q.push_back(e);
    end
    due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    check({tag, "_vld"}, {7'd0, out_valid}, {7'd0, due});
    if (due) begin
      check(tag, mult_ans, exp_q[0].val);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'h5A, 4'hF, 8'h00, "idle");
  endtask

  initial begin
    logic [7:0] p;
    logic [3:0] b;
    logic       v;

    reset     = 1'b1;
    in_valid  = 1'b0;
    potential = '0;
    beta      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", {7'd0, out_valid}, 8'd0);
    check("rst_ans", mult_ans, 8'd0);
    reset = 1'b0;

    step(1'b1, 8'd100, 4'd8, 8'd50, "single");
    idle(5);
    check("hold_ans", mult_ans, 8'd50);

    step(1'b1, 8'd100, 4'd15, 8'd93, "p100b15");
    step(1'b1, 8'h9C, 4'd15, 8'hA2, "m100b15");
    step(1'b1, 8'hFF, 4'd1, 8'hFF, "m1b1");
    step(1'b1, 8'd127, 4'd0, 8'd0, "p127b0");
    step(1'b1, 8'h80, 4'd15, 8'h88, "m128b15");
    step(1'b1, 8'd127, 4'd15, 8'd119, "p127b15");
    idle(6);

    // Async reset with operands in flight after a nonzero result.
    step(1'b1, 8'd64, 4'd9, 8'd0, "inflight");
    step(1'b1, 8'd32, 4'd7, 8'd0, "inflight");
    #2;
    reset = 1'b1;
    #1;
    check("arst_vld", {7'd0, out_valid}, 8'd0);
    check("arst_ans", mult_ans, 8'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    idle(8);
    check("post_rst_ans", mult_ans, 8'd0);

    for (int i = 0; i < 50; i++) begin
      p = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      step(1'b1, p, b, ref_mult(p, b), "stream");
    end
    for (int i = 0; i < 50; i++) begin
      p = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      v = ($urandom_range(0, 2) != 0);
      step(v, p, b, ref_mult(p, b), "bubble");
    end
    idle(6);

    for (int pi = 0; pi < 256; pi++) begin
      for (int bi = 0; bi < 16; bi++) begin
        p = pi[7:0];
        b = bi[3:0];
        step(1'b1, p, b, ref_mult(p, b), "sweep");
      end
    end
    idle(6);
    check("drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
